// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_pkg
// Description : Shared types and default constants for the RO-PUF challenger.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_pkg;

    // Challenger sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int DEF_N_BITS        = 8;
    localparam int DEF_SEL_W         = 4;
    localparam int DEF_CLR_CYCLES    = 2;
    localparam int DEF_MEAS_CYCLES   = 4095;
    localparam int DEF_SETTLE_CYCLES = 4;

    // Timers count 0..P-1, so the widest phase length P needs clog2(P) bits.
    function automatic int timer_width(input int clr, input int meas, input int settle);
        int m;
        m = clr;
        if (meas > m)   m = meas;
        if (settle > m) m = settle;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int DEF_TIMER_W = timer_width(DEF_CLR_CYCLES, DEF_MEAS_CYCLES, DEF_SETTLE_CYCLES);

endpackage
`default_nettype wire

// File: rtl/puf_sync2.sv
`default_nettype none
// ============================================================================
// Module      : puf_sync2
// Description : Two-flop synchronizer for the asynchronous PUF comparison bit.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; first stage may go metastable, second resolves it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/puf_challenger.sv
`default_nettype none
// ============================================================================
// Module      : puf_challenger
// Description : Walks N_BITS oscillator-pair challenges through clear, run,
//               settle and sample phases and assembles the PUF response word.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_challenger
    import puf_pkg::*;
#(
    parameter int N_BITS        = DEF_N_BITS,
    parameter int SEL_W         = DEF_SEL_W,
    parameter int CLR_CYCLES    = DEF_CLR_CYCLES,
    parameter int MEAS_CYCLES   = DEF_MEAS_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SEL_W-1:0]  seed,
    input  logic              puf_in,
    output logic [SEL_W-1:0]  select1,
    output logic [SEL_W-1:0]  select2,
    output logic              ro_enable,
    output logic              ro_reset,
    output logic              busy,
    output logic              done,
    output logic [N_BITS-1:0] response
);

    localparam int TIMER_W = timer_width(CLR_CYCLES, MEAS_CYCLES, SETTLE_CYCLES);
    localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [TIMER_W-1:0] CLR_LAST    = TIMER_W'(CLR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] MEAS_LAST   = TIMER_W'(MEAS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(N_BITS - 1);

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] timer;
    logic [IDX_W-1:0]   idx;
    logic               puf_sync;

    puf_sync2 u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (puf_in),
        .q       (puf_sync)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and Moore decode of the oscillator controls
    always_comb begin
        state_next = state;
        ro_reset   = 1'b0;
        ro_enable  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                ro_reset = 1'b1;
                busy     = 1'b1;
                if (timer == CLR_LAST) state_next = ST_RUN;
            end
            ST_RUN: begin
                ro_enable = 1'b1;
                busy      = 1'b1;
                if (timer == MEAS_LAST) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (timer == SETTLE_LAST) state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy       = 1'b1;
                state_next = (idx == IDX_LAST) ? ST_DONE : ST_CLEAR;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Phase timer: counts within a timed phase, restarts on every phase change
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer <= '0;
        end else if (state_next != state) begin
            timer <= '0;
        end else if (state inside {ST_CLEAR, ST_RUN, ST_SETTLE}) begin
            timer <= timer + 1'b1;
        end
    end

    // Challenge index, oscillator selects and response assembly
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            select1  <= '0;
            select2  <= '0;
            idx      <= '0;
            response <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                select1  <= seed;
                select2  <= seed + 1'b1;
                idx      <= '0;
                response <= '0;
            end else if (state == ST_SAMPLE) begin
                response[idx] <= puf_sync;
                if (idx != IDX_LAST) begin
                    // Next pair is two oscillators further on; wrap by truncation
                    idx     <= idx + 1'b1;
                    select1 <= select1 + SEL_W'(2);
                    select2 <= select1 + SEL_W'(3);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_challenger.sv
`default_nettype none
// ============================================================================
// Module      : tb_puf_challenger
// Description : Self-checking bench for puf_challenger (table-driven runs plus
//               start-injection, mid-run reset and synchronizer sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_puf_challenger;

    localparam int N    = 4;
    localparam int SW   = 4;
    localparam int CLR  = 2;
    localparam int MEAS = 16;
    localparam int SET  = 4;
    localparam int LAT  = 1 + N * (CLR + MEAS + SET + 1);

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic [SW-1:0] seed    = '0;
    logic          puf_in  = 1'b0;
    logic [SW-1:0] select1, select2;
    logic          ro_enable, ro_reset, busy, done;
    logic [N-1:0]  response;

    int checks = 0;
    int errors = 0;

    // Environment PUF model configuration
    int          mode       = 0;
    logic [3:0]  run_seed   = '0;
    int          settle_cnt = 0;

    puf_challenger #(
        .N_BITS        (N),
        .SEL_W         (SW),
        .CLR_CYCLES    (CLR),
        .MEAS_CYCLES   (MEAS),
        .SETTLE_CYCLES (SET)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .seed      (seed),
        .puf_in    (puf_in),
        .select1   (select1),
        .select2   (select2),
        .ro_enable (ro_enable),
        .ro_reset  (ro_reset),
        .busy      (busy),
        .done      (done),
        .response  (response)
    );

    always #5 clock = ~clock;

    // 0: always 1; 1: select1 odd; 2/3: challenge index odd
    function automatic logic model(input int m, input logic [3:0] s1, input logic [3:0] sd);
        logic [3:0] d;
        d = s1 - sd;
        case (m)
            0:       return 1'b1;
            1:       return s1[0];
            default: return d[1];
        endcase
    endfunction

    // PUF driver; mode 3 inverts the bit from the last settle cycle onward,
    // which the two-flop synchronizer must not yet see at sample time
    always @(negedge clock) begin
        if (ro_enable || ro_reset || !busy) settle_cnt <= 0;
        else                                settle_cnt <= settle_cnt + 1;
        if (mode == 3 && settle_cnt >= SET - 1) puf_in <= ~model(mode, select1, run_seed);
        else                                    puf_in <= model(mode, select1, run_seed);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel1"}, 32'(select1), 32'd0);
        check({tag, "_sel2"}, 32'(select2), 32'd0);
        check({tag, "_ctrl"}, {28'd0, ro_enable, ro_reset, busy, done}, 32'd0);
        check({tag, "_resp"}, 32'(response), 32'd0);
    endtask

    // One complete run from an IDLE start to the done pulse
    task automatic run(input logic [3:0] s, input int m, input logic [N-1:0] exp_resp,
                       input string tag, input bit inject);
        int   cyc, nclr, nen, nbusy, nsel, selerr, ovl;
        logic prev_rr;
        logic [N-1:0] held;
        mode = m; run_seed = s;
        nclr = 0; nen = 0; nbusy = 0; nsel = 0; selerr = 0; ovl = 0; prev_rr = 1'b0;
        @(negedge clock);
        seed  = s;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        seed  = ~s;
        cyc   = 1;
        forever begin
            @(negedge clock);
            if (start) start = 1'b0;
            if (ro_reset)  nclr++;
            if (ro_enable) nen++;
            if (busy)      nbusy++;
            if (ro_reset && ro_enable) ovl++;
            if (busy && select2 !== select1 + 4'd1) selerr++;
            if (ro_reset && !prev_rr) begin
                if (select1 !== s + 4'(2 * nsel)) selerr++;
                nsel++;
            end
            prev_rr = ro_reset;
            if (inject && (cyc == 10 || done)) begin
                start = 1'b1;
                seed  = s + 4'd1;
            end
            if (done) break;
            if (cyc >= LAT + 50) break;
            @(posedge clock);
            cyc++;
        end
        check({tag, "_done_cycle"}, 32'(cyc), 32'(LAT));
        check({tag, "_response"}, 32'(response), 32'(exp_resp));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_clr_cycles"}, 32'(nclr), 32'(N * CLR));
        check({tag, "_en_cycles"}, 32'(nen), 32'(N * MEAS));
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'(LAT - 1));
        check({tag, "_challenges"}, 32'(nsel), 32'(N));
        check({tag, "_select_errs"}, 32'(selerr + ovl), 32'd0);
        held = response;
        @(negedge clock);
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        // Stay idle: a start seen in the DONE cycle must not launch a run
        repeat (4) @(negedge clock);
        check({tag, "_idle_after"}, {30'd0, busy, ro_reset}, 32'd0);
        check({tag, "_resp_held"}, 32'(response), 32'(held));
    endtask

    typedef struct {
        logic [3:0]   s;
        int           m;
        logic [N-1:0] exp_resp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{s: 4'd3,  m: 0, exp_resp: 4'b1111};  // baseline
        vecs[1] = '{s: 4'd0,  m: 1, exp_resp: 4'b0000};  // all selects even
        vecs[2] = '{s: 4'd1,  m: 1, exp_resp: 4'b1111};  // all selects odd
        vecs[3] = '{s: 4'd0,  m: 2, exp_resp: 4'b1010};  // toggle by index
        vecs[4] = '{s: 4'd14, m: 2, exp_resp: 4'b1010};  // 14,0,2,4 wrap
        vecs[5] = '{s: 4'd15, m: 1, exp_resp: 4'b1111};  // select2 wraps 15->0

        #12;
        check_reset_outputs("por");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_reset_outputs("idle");

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].s, vecs[i].m, vecs[i].exp_resp, $sformatf("vec%0d", i), 1'b0);
        end

        // start pulses during RUN and during DONE are ignored
        run(4'd5, 1, 4'b1111, "inject", 1'b1);

        // Synchronizer latency: late toggle of puf_in must not be captured
        run(4'd6, 3, 4'b1010, "sync", 1'b0);

        // Async reset mid-RUN of challenge 2, partial response discarded
        mode = 2; run_seed = 4'd9;
        @(negedge clock);
        seed  = 4'd9;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2 * (CLR + MEAS + SET + 1) + CLR + 5) @(posedge clock);
        #2;
        check("midrun_enable", 32'(ro_enable), 32'd1);
        check("midrun_partial", 32'(response), 32'b0010);
        check("midrun_sel1", 32'(select1), 32'd13);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clock);
        reset_n = 1'b1;
        run(4'd0, 1, 4'b0000, "post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/puf_challenger.md
Name: puf_challenger

Overview:
Initiator side of the ring-oscillator PUF. On a start pulse it walks a sequence of N_BITS oscillator-pair challenges. For each challenge it drives the mux selects and the counter clear/enable controls, waits a fixed measurement window, then samples the PUF comparison bit. The bits are assembled into an N_BITS response word with a done pulse, replacing manual VIO challenge entry.

Parameters:
N_BITS, 8, response bits collected per run (1..32)
SEL_W, 4, width of each oscillator select (16 oscillators)
CLR_CYCLES, 2, cycles ro_reset is held high before each measurement (>=1)
MEAS_CYCLES, 4095, cycles ro_enable is held high per measurement (>=1)
SETTLE_CYCLES, 4, cycles after enable drops before sampling (>=3, covers synchronizer)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
seed  in  SEL_W  base oscillator index for the run
puf_in  in  1  PUF comparison bit (asynchronous to clock; synchronized internally)
select1  out  SEL_W  mux-1 oscillator select
select2  out  SEL_W  mux-2 oscillator select
ro_enable  out  1  oscillator/counter enable (active high)
ro_reset  out  1  counter clear (active high)
busy  out  1  high from the cycle after start is accepted until DONE completes
done  out  1  one-cycle pulse; response valid
response  out  N_BITS  collected response; bit i is challenge i

Behaviour:
- Reset (async, reset_n=0): state IDLE; select1=select2=0; ro_enable=0; ro_reset=0; busy=0; done=0; response=0; idx=0; all timers 0.
- States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches seed, sets idx=0 and clears response to 0, then goes to CLEAR.
  - start=0 stays in IDLE.
- Selects for challenge idx:
  - select1 = (seed + 2*idx) mod 2^SEL_W; select2 = select1 + 1 mod 2^SEL_W.
  - Wrap is natural truncation, e.g. seed=15, idx=0 gives select1=15, select2=0.
  - Selects are registered and stable through CLEAR, RUN, SETTLE and SAMPLE for that challenge.
- CLEAR: ro_reset=1, ro_enable=0 for exactly CLR_CYCLES cycles, then RUN.
- RUN: ro_reset=0, ro_enable=1 for exactly MEAS_CYCLES cycles, then SETTLE.
- SETTLE: ro_enable=0, ro_reset=0 for SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (1 cycle):
  - response[idx] is loaded with the 2-flop-synchronized puf_in.
  - If idx==N_BITS-1, go to DONE; else idx+1, go to CLEAR.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- response holds its value after DONE until the next accepted start.
- busy: 1 in CLEAR, RUN, SETTLE and SAMPLE; 0 in IDLE and DONE.
- Latency: start accepted in cycle 0; done is high in cycle 1 + N_BITS*(CLR_CYCLES+MEAS_CYCLES+SETTLE_CYCLES+1).
- start while not IDLE (including the DONE cycle) is ignored; it is not queued.
- seed changes after acceptance have no effect on the current run.
- reset_n low mid-run: immediate return to reset values; the partial response is discarded (cleared to 0).
- Timers are sized for the largest parameter value, e.g. 12 bits for MEAS_CYCLES=4095. No overflow is possible because each timer compares to its parameter minus 1.

Decomposition:
- Shared package puf_pkg:
  - state enum (IDLE..DONE);
  - default constants for N_BITS, SEL_W, CLR_CYCLES, MEAS_CYCLES, SETTLE_CYCLES;
  - timer width constant derived from MEAS_CYCLES.
- One sub-module: puf_sync2, a 2-flop synchronizer for puf_in with async active-low reset to 0.
- FSM, timer and response shift logic live in puf_challenger.

Test Plan:
- Baseline run (N_BITS=4, CLR=2, MEAS=16, SETTLE=4, seed=3, puf_in held 1):
  - selects step (3,4),(5,6),(7,8),(9,10);
  - ro_reset high 2 cycles then ro_enable high 16 cycles per challenge;
  - done high exactly at cycle 93; response=4'b1111.
- Per-challenge model: a PUF model returns 1 when select1 is odd, with seed=0 -> all selects even -> response=4'b0000. With seed=1 -> response=4'b1111. Repeat with a model toggling by idx -> response=4'b1010.
- Wrap: seed=14, N_BITS=2 -> selects (14,15) then (0,1); no out-of-range values.
- start pulsed during RUN and during the DONE cycle -> ignored. Exactly one done; the second run begins only on a start issued in IDLE.
- reset_n asserted mid-RUN of challenge 2 -> all outputs return to reset values asynchronously (same cycle). A new start after release produces a full, correct response with no stale bits.
- puf_in toggling asynchronously near SAMPLE -> the captured bit equals the synchronized value from 2 cycles earlier; no X on response.
